// File: rtl/dmem_mmio.sv
// dmem_mmio: data RAM plus memory-mapped LED, free-running cycle counter,
// timer compare and status registers for a single-cycle core.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset      synchronous active-high reset
//   memwrite   store strobe from the core
//   alu_result byte address from the core
//   writedata  store data from the core
//   readdata   combinational load data (zero-cycle latency)
//   leds       LED register contents
//   irq        timer interrupt pending flag
//   bus_err    sticky flag raised by a store to an unmapped/misaligned address
//
// Address map (word aligned only):
//   0x0000_0000 .. RAM_WORDS*4-1  data RAM
//   0xFFFF_0000  LED     (rw)
//   0xFFFF_0004  CYCLE   (ro, stores ignored)
//   0xFFFF_0008  CMP     (rw)
//   0xFFFF_000C  STATUS  (bit0 irq, bit1 bus_err; write-1-to-clear)
module dmem_mmio #(
  parameter int unsigned RAM_WORDS = 64,
  parameter int unsigned LED_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 memwrite,
  input  logic [31:0]          alu_result,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 irq,
  output logic                 bus_err
);

  localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  logic [31:0]          ram [RAM_WORDS];
  logic [31:0]          cycle_q;
  logic [31:0]          cmp_q;
  logic [LED_WIDTH-1:0] led_q;
  logic                 irq_q;
  logic                 bus_err_q;

  logic          aligned;
  logic          ram_hit;
  logic          mmio_page;
  logic          led_hit;
  logic          cyc_hit;
  logic          cmp_hit;
  logic          status_hit;
  logic          illegal_store;
  logic          timer_hit;
  logic          irq_clr;
  logic          err_clr;
  logic [AW-1:0] word_idx;

  // Address decode; every hit already implies a word-aligned address.
  assign aligned    = (alu_result[1:0] == 2'b00);
  assign word_idx   = alu_result[AW+1:2];
  assign ram_hit    = aligned && (alu_result[31:AW+2] == '0);
  assign mmio_page  = aligned && (alu_result[31:4] == 28'hFFFF_000);
  assign led_hit    = mmio_page && (alu_result[3:2] == 2'd0);
  assign cyc_hit    = mmio_page && (alu_result[3:2] == 2'd1);
  assign cmp_hit    = mmio_page && (alu_result[3:2] == 2'd2);
  assign status_hit = mmio_page && (alu_result[3:2] == 2'd3);

  assign illegal_store = memwrite &&
                         !(ram_hit || led_hit || cyc_hit || cmp_hit || status_hit);
  assign timer_hit     = (cmp_q != '0) && (cycle_q == cmp_q);
  assign irq_clr       = memwrite && status_hit && writedata[0];
  assign err_clr       = memwrite && status_hit && writedata[1];

  always_comb begin
    readdata = '0;
    if (ram_hit) begin
      readdata = ram[word_idx];
    end else if (led_hit) begin
      readdata[LED_WIDTH-1:0] = led_q;
    end else if (cyc_hit) begin
      readdata = cycle_q;
    end else if (cmp_hit) begin
      readdata = cmp_q;
    end else if (status_hit) begin
      readdata[1:0] = {bus_err_q, irq_q};
    end
  end

  // RAM is deliberately left out of reset; stores during reset are dropped.
  always_ff @(posedge clk) begin
    if (!reset && memwrite && ram_hit) begin
      ram[word_idx] <= writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q   <= '0;
      cmp_q     <= '0;
      led_q     <= '0;
      irq_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (memwrite && led_hit) begin
        led_q <= writedata[LED_WIDTH-1:0];
      end
      if (memwrite && cmp_hit) begin
        cmp_q <= writedata;
      end
      // Setting events take priority over a concurrent write-1-to-clear.
      irq_q     <= timer_hit || (irq_q && !irq_clr);
      bus_err_q <= illegal_store || (bus_err_q && !err_clr);
    end
  end

  assign leds    = led_q;
  assign irq     = irq_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: stimulus pushes expected responses computed
// by a behavioural model; a monitor pops and compares them each cycle.
module tb_dmem_mmio;

  localparam int unsigned RW = 64;
  localparam int unsigned LW = 8;
  localparam logic [31:0] A_LED  = 32'hFFFF_0000;
  localparam logic [31:0] A_CYC  = 32'hFFFF_0004;
  localparam logic [31:0] A_CMP  = 32'hFFFF_0008;
  localparam logic [31:0] A_STAT = 32'hFFFF_000C;

  logic          clk = 1'b0;
  logic          reset;
  logic          memwrite;
  logic [31:0]   alu_result;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [LW-1:0] leds;
  logic          irq;
  logic          bus_err;

  dmem_mmio #(.RAM_WORDS(RW), .LED_WIDTH(LW)) dut (
    .clk        (clk),
    .reset      (reset),
    .memwrite   (memwrite),
    .alu_result (alu_result),
    .writedata  (writedata),
    .readdata   (readdata),
    .leds       (leds),
    .irq        (irq),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [31:0]   m_ram [RW];
  logic [31:0]   m_cycle = '0;
  logic [31:0]   m_cmp   = '0;
  logic [LW-1:0] m_leds  = '0;
  logic          m_irq   = 1'b0;
  logic          m_berr  = 1'b0;

  typedef struct {
    string         tag;
    logic [31:0]   rd;
    logic [LW-1:0] led;
    logic          irq;
    logic          berr;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   done   = 1'b0;

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    if (a % 4 != 0) r = '0;
    else if (a < 32'(RW * 4)) r = m_ram[a / 4];
    else if (a == A_LED) r = 32'(m_leds);
    else if (a == A_CYC) r = m_cycle;
    else if (a == A_CMP) r = m_cmp;
    else if (a == A_STAT) r = {30'd0, m_berr, m_irq};
    return r;
  endfunction

  task automatic mdl_step(input logic rst, input logic we,
                          input logic [31:0] a, input logic [31:0] d);
    logic [31:0] old_cmp;
    logic        n_irq, n_berr;
    if (rst) begin
      m_cycle = '0; m_cmp = '0; m_leds = '0; m_irq = 1'b0; m_berr = 1'b0;
      return;
    end
    old_cmp = m_cmp;
    n_irq   = m_irq;
    n_berr  = m_berr;
    if (we) begin
      if (a % 4 == 0 && a < 32'(RW * 4)) m_ram[a / 4] = d;
      else if (a == A_LED) m_leds = d[LW-1:0];
      else if (a == A_CMP) m_cmp = d;
      else if (a == A_STAT) begin
        if (d[0]) n_irq = 1'b0;
        if (d[1]) n_berr = 1'b0;
      end
      else if (a == A_CYC) begin end
      else n_berr = 1'b1;
    end
    if (old_cmp != 0 && m_cycle == old_cmp) n_irq = 1'b1;
    m_irq   = n_irq;
    m_berr  = n_berr;
    m_cycle = m_cycle + 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge and queue the expected response.
  task automatic cyc(input logic rst, input logic we, input logic [31:0] a,
                     input logic [31:0] d, input string tag);
    exp_t e;
    reset = rst; memwrite = we; alu_result = a; writedata = d;
    e.tag = tag; e.rd = mdl_read(a); e.led = m_leds; e.irq = m_irq; e.berr = m_berr;
    q.push_back(e);
    @(posedge clk);
    mdl_step(rst, we, a, d);
    @(negedge clk);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk({e.tag, ".readdata"}, readdata, e.rd);
        chk({e.tag, ".leds"}, 32'(leds), 32'(e.led));
        chk({e.tag, ".irq"}, 32'(irq), 32'(e.irq));
        chk({e.tag, ".bus_err"}, 32'(bus_err), 32'(e.berr));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 8))
      0, 1, 2, 3: a = 32'($urandom_range(0, RW - 1)) * 4;
      4: a = 32'($urandom_range(0, RW - 1)) * 4 + 32'($urandom_range(1, 3));
      5, 6: a = A_LED + 32'($urandom_range(0, 3)) * 4;
      7: a = A_LED + 32'($urandom_range(0, 15)) + 32'($urandom_range(1, 3)) * 16;
      default: a = 32'h0001_0000 + 32'($urandom_range(0, 16'hFFFF)) * 4;
    endcase
    return a;
  endfunction

  initial begin
    logic [31:0] a, d, v, old5;
    int unsigned guard;

    reset = 1'b1; memwrite = 1'b0; alu_result = A_LED; writedata = '0;
    @(posedge clk);
    @(negedge clk);
    cyc(1, 1, 32'h0, 32'h1234_5678, "reset_state");

    for (int unsigned i = 0; i < RW; i++)
      cyc(0, 1, 32'(i * 4), $urandom, "ram_init");

    // Store/load RAM; neighbour word untouched
    cyc(0, 1, 32'h10, 32'hDEAD_BEEF, "ram_store");
    cyc(0, 0, 32'h10, '0, "ram_read10");
    cyc(0, 0, 32'h14, '0, "ram_read14");

    // LED
    cyc(0, 1, A_LED, 32'h0000_01A5, "led_store");
    cyc(0, 0, A_LED, '0, "led_read");

    // Timer
    cyc(1, 0, A_CYC, '0, "timer_reset");
    cyc(0, 1, A_CMP, 32'd5, "cmp_store");
    for (int unsigned i = 0; i < 7; i++) cyc(0, 0, A_CYC, '0, "timer_run");
    cyc(0, 0, A_STAT, '0, "status_irq");
    cyc(0, 1, A_STAT, 32'h1, "irq_clear");
    cyc(0, 1, A_CMP, m_cycle + 3, "cmp_ahead");
    guard = 0;
    while (m_cycle != m_cmp && guard < 10) begin
      cyc(0, 0, A_CMP, '0, "cmp_wait");
      guard++;
    end
    cyc(0, 1, A_STAT, 32'h1, "irq_set_wins");
    cyc(0, 0, A_STAT, '0, "irq_after_tie");

    // Bus errors
    cyc(0, 1, 32'h12, 32'hCAFE_0001, "misaligned_store");
    cyc(0, 0, 32'h10, '0, "ram_unchanged");
    cyc(0, 1, 32'h0001_0000, 32'hCAFE_0002, "unmapped_store");
    cyc(0, 0, 32'h0001_0000, '0, "unmapped_read");
    cyc(0, 0, 32'h0000_0013, '0, "misaligned_read");
    cyc(0, 1, A_STAT, 32'h2, "berr_clear");
    cyc(0, 0, A_STAT, '0, "status_after_clr");
    cyc(0, 1, A_CYC, 32'h5555_5555, "cycle_store_ign");
    cyc(0, 0, A_CYC, '0, "cycle_read");

    // Randomized traffic
    for (int unsigned i = 0; i < 400; i++) begin
      a = rand_addr();
      d = $urandom;
      if (a == A_CMP) d = m_cycle + 32'($urandom_range(1, 6));
      cyc($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)), a, d, "random");
    end

    // Reset overrides pending state and concurrent RAM store
    cyc(0, 1, A_LED, 32'hFF, "led_ff");
    cyc(0, 1, A_CMP, m_cycle + 1, "cmp_next");
    cyc(0, 0, A_STAT, '0, "irq_pending_wait");
    cyc(0, 0, A_STAT, '0, "irq_pending");
    old5 = m_ram[5];
    cyc(1, 1, 32'h14, ~old5, "reset_with_store");
    cyc(0, 0, 32'h14, '0, "ram_kept");
    cyc(0, 0, A_LED, '0, "led_after_reset");

    // Counter wrap via preload
    cyc(1, 0, A_LED, '0, "wrap_reset");
    force dut.cycle_q = 32'hFFFF_FFFE;
    cyc(0, 0, A_LED, '0, "wrap_hold");
    release dut.cycle_q;
    memwrite = 1'b0; alu_result = A_CYC;
    #1;
    v = readdata;
    checks++;
    if (v !== 32'hFFFF_FFFE && v !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_preload: got %h expected fffffffe or ffffffff", v);
      v = 32'hFFFF_FFFE;
    end
    m_cycle = v;
    for (int unsigned i = 0; i < 3; i++) cyc(0, 0, A_CYC, '0, "wrap_read");
    cyc(0, 1, A_CYC, 32'hFFFF_FFF0, "wrap_cyc_store");
    cyc(0, 0, A_STAT, '0, "wrap_status");

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d expected 0 pending", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
